// File: rtl/cyl_result_serializer_if.sv
// Handshake bundle between the converter, the serializer and the byte pins.
// The slave side is the serializer: it takes the triple and drives the byte bus.
interface cyl_result_serializer_if;
  // triple from the converter
  logic [15:0] in_r;
  logic [15:0] in_theta;
  logic [15:0] in_z;
  logic        in_valid;
  logic        in_ready;
  // byte stream towards the chip pins
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  modport slave (
    input  in_r, in_theta, in_z, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );

  modport master (
    output in_r, in_theta, in_z, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/cyl_result_serializer.sv
// Result serializer: captures one {r, theta, z} triple and streams it as
// bytes (optionally followed by an XOR checksum byte) with valid/ready/last.
// A new triple can be taken on the same edge the last byte leaves, so
// consecutive frames go out with no idle cycle between them.
module cyl_result_serializer #(
  parameter bit CHECKSUM_EN = 1'b1,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  cyl_result_serializer_if.slave   bus,
  output logic                     busy,
  output logic [7:0]               frame_cnt
);

  localparam int         NWORDS   = 3;
  localparam int         NBYTES   = 6 + int'(CHECKSUM_EN);
  localparam logic [2:0] LAST_IDX = 3'(NBYTES - 1);

  typedef enum logic {IDLE, SEND} state_e;

  state_e                        state_q, state_d;
  logic [2:0]                    idx_q, idx_d;
  logic [NWORDS-1:0][15:0]       word_q, word_d;
  logic [7:0]                    chk_q, chk_d;
  logic [7:0]                    frame_cnt_q, frame_cnt_d;

  // word 0 is r, word 1 theta, word 2 z: this is also the transmit order
  logic [NWORDS-1:0][15:0]       in_word;
  logic [7:0]                    in_chk;
  // 8 slots so a 3-bit index is always in range; unused slots read as zero
  logic [7:0][7:0]               frame_bytes;

  logic take;
  logic is_last;
  logic accept;

  assign in_word = {bus.in_z, bus.in_theta, bus.in_r};

  assign take    = (state_q == SEND) && bus.out_ready;
  assign is_last = (idx_q == LAST_IDX);

  // Ready while idle, or when the final byte is being taken this cycle so the
  // next frame follows without a bubble. Held low throughout reset.
  assign bus.in_ready = !rst && ((state_q == IDLE) || (take && is_last));
  assign accept       = bus.in_valid && bus.in_ready;

  // Checksum is built from the incoming triple so it is ready at the accept edge
  always_comb begin
    in_chk = 8'h00;
    for (int w = 0; w < NWORDS; w++) begin
      in_chk = in_chk ^ in_word[w][15:8] ^ in_word[w][7:0];
    end
  end

  // Lay out the held frame byte by byte; byte order within a word follows MSB_FIRST
  always_comb begin
    frame_bytes = '0;
    for (int w = 0; w < NWORDS; w++) begin
      if (MSB_FIRST) begin
        frame_bytes[2*w]   = word_q[w][15:8];
        frame_bytes[2*w+1] = word_q[w][7:0];
      end else begin
        frame_bytes[2*w]   = word_q[w][7:0];
        frame_bytes[2*w+1] = word_q[w][15:8];
      end
    end
    if (CHECKSUM_EN) frame_bytes[6] = chk_q;
  end

  // Next state: advance on each taken byte, close the frame on the last one,
  // and load a new triple whenever one is accepted
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    word_d      = word_q;
    chk_d       = chk_q;
    frame_cnt_d = frame_cnt_q;
    if (take) begin
      idx_d = idx_q + 3'd1;
      if (is_last) begin
        frame_cnt_d = frame_cnt_q + 8'd1;
        state_d     = IDLE;
        idx_d       = 3'd0;
      end
    end
    if (accept) begin
      word_d  = in_word;
      chk_d   = in_chk;
      idx_d   = 3'd0;
      state_d = SEND;
    end
  end

  // State and frame registers; reset drops any partly sent frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= 3'd0;
      word_q      <= '0;
      chk_q       <= 8'h00;
      frame_cnt_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      word_q      <= word_d;
      chk_q       <= chk_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Byte bus is a pure decode of registered state, so it holds while stalled
  // and drops as soon as reset clears the state
  always_comb begin
    bus.out_valid = (state_q == SEND);
    bus.out_last  = (state_q == SEND) && is_last;
    bus.out_data  = (state_q == SEND) ? frame_bytes[idx_q] : 8'h00;
  end

  assign busy      = (state_q == SEND);
  assign frame_cnt = frame_cnt_q;

endmodule
